fp_normalize_seq: RTL and testbench
===================================

# fp_normalize_seq

Multi-cycle normalization sequencer for the FP add/sub datapath. It accepts an unnormalized 33-bit mantissa and its exponent, then left-shifts the mantissa until the MSB is set. Each cycle it drives one pass through the existing 0–15-bit normalize shifter, decrementing the exponent to match, and flags zero and underflow results. It sits between the adder stage and rounding, with valid/ready handshakes on both sides.

## Interface
- EXP_W, default 8: exponent width in bits.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream has a mantissa/exponent pair.
- in_ready  out  1  block is idle and can accept.
- in_mant  in  33  unnormalized mantissa; bit 32 is the hidden-bit position.
- in_exp  in  EXP_W  unbiased-stored exponent of in_mant.
- out_valid  out  1  result held and valid.
- out_ready  in  1  downstream accepts the result.
- out_mant  out  33  normalized mantissa.
- out_exp  out  EXP_W  adjusted exponent.
- out_shift  out  6  total left shift applied, 0–32.
- out_zero  out  1  input mantissa was zero.
- out_underflow  out  1  exponent reached 0 before normalization completed.

## Operation
- States: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE), driven combinationally from the state register.
- IDLE: on in_valid && in_ready, register mant, exp, shift=0, zero=0, uf=0, then go to SHIFT.
- SHIFT: evaluate the registered mant each cycle, in this priority order:
  - mant == 0: zero=1, exp=0, go to DONE.
  - mant[32] == 1: go to DONE, no shift.
  - exp == 0: uf=1, go to DONE.
  - else: amt = min(lzc(mant), 15, exp); mant <= mant << amt (zero fill); exp <= exp − amt; shift <= shift + amt; stay in SHIFT.
- amt is never 0 in the shift branch, because lzc ≥ 1 and exp ≥ 1 there. This guarantees progress; at most 3 shift passes occur.
- The exponent never wraps, because amt ≤ exp.
- DONE: out_valid=1; all out_* are driven from registers and stay stable while out_ready=0. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Reset (any state, asynchronous): state=IDLE, all registers cleared, any in-flight operation discarded. Output values while/after reset: in_ready=1, out_valid=0, out_mant=0, out_exp=0, out_shift=0, out_zero=0, out_underflow=0.

## Timing
- Accept at edge T; first SHIFT evaluation in cycle T+1.
- Latency from accept to out_valid = 2 + (number of shift passes) cycles.
  - Already-normalized or zero input: out_valid at T+2.
  - lzc = 20, exp ample: passes of 15 and 5, out_valid at T+4.
- Handshake completes on the edge where out_valid && out_ready. in_ready rises the next cycle; there is no same-cycle accept bypass, so the block is fully serialized.
- Throughput: one operation per (latency + 1) cycles at best.

## Structure
- Package fp_norm_pkg holds:
  - state enum norm_state_t {IDLE, SHIFT, DONE};
  - localparams MANT_W=33, SHIFT_MAX=15, SHCNT_W=6.
- Sub-module lzc33: combinational 33-bit leading-zero counter, 6-bit output; returns 33 for zero input.
- The shift itself is one instance of the team's existing FPAddSub_NormalizeShift1, fed by the mantissa register and a 4-bit amt.
- The top level is the FSM plus the min/subtract logic and the output registers.

## Test plan
- in_mant=33'h1_0000_0000, in_exp=100 → out_mant unchanged, out_exp=100, out_shift=0, zero=0, uf=0, out_valid at T+2.
- in_mant=33'h0_0000_1000 (lzc 20), in_exp=100 → out_mant=33'h1_0000_0000, out_exp=80, out_shift=20, out_valid at T+4.
- in_mant=0, in_exp=55 → out_zero=1, out_mant=0, out_exp=0, out_shift=0, out_valid at T+2.
- in_mant=33'h0_0000_0001, in_exp=10 → one pass of 10, out_mant=33'h0_0000_0400, out_exp=0, out_shift=10, out_underflow=1, out_valid at T+3.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid meanwhile → outputs stable, in_ready=0, no new accept. Raise out_ready → in_ready=1 on the next cycle.
- Assert rst in the middle of a SHIFT pass of the lzc-20 case → immediately in_ready=1, out_valid=0, all outputs 0. A new input after reset release completes normally.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared types and sizing for the FP normalization sequencer.
package fp_norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_t;

  localparam int MANT_W    = 33;
  localparam int SHIFT_MAX = 15;
  localparam int SHCNT_W   = 6;

endpackage

// File: rtl/FPAddSub_NormalizeShift1.sv
// Single-pass 0-15 bit left shifter used by the FP add/sub normalize stage; zero fill.
module FPAddSub_NormalizeShift1
  import fp_norm_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic [3:0]        amt,
  output logic [MANT_W-1:0] shifted
);

  // Plain logical left shift; bits shifted past the MSB are dropped.
  always_comb begin
    shifted = mant << amt;
  end

endmodule

// File: rtl/lzc33.sv
// Combinational leading-zero counter for a 33-bit mantissa; all-zero input yields 33.
module lzc33
  import fp_norm_pkg::*;
(
  input  logic [MANT_W-1:0]  mant,
  output logic [SHCNT_W-1:0] cnt
);

  // Ascending scan so the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = SHCNT_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (mant[i]) cnt = SHCNT_W'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_seq.sv
// Multi-cycle mantissa normalizer: one bounded shift pass per cycle until the
// hidden bit is set, the mantissa is zero, or the exponent runs out.
//
// state | meaning
// IDLE  | waiting for an input pair, in_ready high
// SHIFT | evaluating the registered mantissa, one shift pass per cycle
// DONE  | result held on out_* until out_ready
module fp_normalize_seq
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MANT_W-1:0]   in_mant,
  input  logic [EXP_W-1:0]    in_exp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MANT_W-1:0]   out_mant,
  output logic [EXP_W-1:0]    out_exp,
  output logic [SHCNT_W-1:0]  out_shift,
  output logic                out_zero,
  output logic                out_underflow
);

  norm_state_t          state;
  logic [MANT_W-1:0]    mant_r;
  logic [EXP_W-1:0]     exp_r;
  logic [SHCNT_W-1:0]   shift_r;
  logic                 zero_r;
  logic                 uf_r;

  logic [SHCNT_W-1:0]   lzc;
  logic [3:0]           lz_cap;
  logic [3:0]           amt;
  logic [EXP_W+3:0]     exp_ext;
  logic [EXP_W+3:0]     cap_ext;
  logic [MANT_W-1:0]    shifted;

  lzc33 u_lzc (
    .mant (mant_r),
    .cnt  (lzc)
  );

  FPAddSub_NormalizeShift1 u_shift (
    .mant    (mant_r),
    .amt     (amt),
    .shifted (shifted)
  );

  // amt = min(lzc, 15, exp); capping by exp keeps the exponent from wrapping.
  always_comb begin
    lz_cap  = (lzc > SHCNT_W'(SHIFT_MAX)) ? 4'(SHIFT_MAX) : lzc[3:0];
    exp_ext = {4'b0000, exp_r};
    cap_ext = {{EXP_W{1'b0}}, lz_cap};
    amt     = (exp_ext < cap_ext) ? exp_ext[3:0] : lz_cap;
  end

  // Sequencer state and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mant_r  <= '0;
      exp_r   <= '0;
      shift_r <= '0;
      zero_r  <= 1'b0;
      uf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mant_r  <= in_mant;
            exp_r   <= in_exp;
            shift_r <= '0;
            zero_r  <= 1'b0;
            uf_r    <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (mant_r == '0) begin
            zero_r <= 1'b1;
            exp_r  <= '0;
            state  <= DONE;
          end else if (mant_r[MANT_W-1]) begin
            state <= DONE;
          end else if (exp_r == '0) begin
            uf_r  <= 1'b1;
            state <= DONE;
          end else begin
            mant_r  <= shifted;
            exp_r   <= exp_r - EXP_W'(amt);
            shift_r <= shift_r + SHCNT_W'(amt);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags straight off the state register; data off the result registers.
  always_comb begin
    in_ready      = (state == IDLE);
    out_valid     = (state == DONE);
    out_mant      = mant_r;
    out_exp       = exp_r;
    out_shift     = shift_r;
    out_zero      = zero_r;
    out_underflow = uf_r;
  end

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Directed checks for fp_normalize_seq: latency, results, backpressure, reset.
module tb_fp_normalize_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_mant;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_mant;
  logic [7:0]  out_exp;
  logic [5:0]  out_shift;
  logic        out_zero;
  logic        out_underflow;

  int n_chk = 0;
  int n_err = 0;

  fp_normalize_seq #(.EXP_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mant       (in_mant),
    .in_exp        (in_exp),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mant      (out_mant),
    .out_exp       (out_exp),
    .out_shift     (out_shift),
    .out_zero      (out_zero),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // Accept one pair, wait for out_valid, check latency and held results.
  task automatic run_op(input string tag, input logic [32:0] m, input logic [7:0] e,
                        input int lat, input logic [32:0] em, input logic [7:0] ee,
                        input logic [5:0] es, input logic ez, input logic eu);
    int cyc;
    @(negedge clk);
    in_mant  = m;
    in_exp   = e;
    in_valid = 1'b1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      cyc = i;
      if (out_valid) break;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " mant"},  64'(out_mant), 64'(em));
    chk({tag, " exp"},   64'(out_exp), 64'(ee));
    chk({tag, " shift"}, 64'(out_shift), 64'(es));
    chk({tag, " zero"},  64'(out_zero), 64'(ez));
    chk({tag, " uf"},    64'(out_underflow), 64'(eu));
  endtask

  // Complete the output handshake; in_ready must only rise on the following cycle.
  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    chk({tag, " rdy_before"}, 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, " rdy_after"}, 64'(in_ready), 64'd1);
    chk({tag, " vld_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst in_ready",  64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst outs", 64'({out_mant, out_exp, out_shift, out_zero, out_underflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("norm", 33'h1_0000_0000, 8'd100, 2, 33'h1_0000_0000, 8'd100, 6'd0, 1'b0, 1'b0);
    release_out("norm");
    run_op("lzc20", 33'h0_0000_1000, 8'd100, 4, 33'h1_0000_0000, 8'd80, 6'd20, 1'b0, 1'b0);
    release_out("lzc20");
    run_op("zero", 33'h0, 8'd55, 2, 33'h0, 8'd0, 6'd0, 1'b1, 1'b0);
    release_out("zero");
    run_op("uf10", 33'h0_0000_0001, 8'd10, 3, 33'h0_0000_0400, 8'd0, 6'd10, 1'b0, 1'b1);
    release_out("uf10");
    run_op("uf20", 33'h0_0000_0001, 8'd20, 4, 33'h0_0010_0000, 8'd0, 6'd20, 1'b0, 1'b1);
    release_out("uf20");
    run_op("lzc32", 33'h0_0000_0001, 8'd100, 5, 33'h1_0000_0000, 8'd68, 6'd32, 1'b0, 1'b0);
    release_out("lzc32");

    // Backpressure: hold the result for 5 cycles while upstream offers new data.
    run_op("bp", 33'h0_0000_1000, 8'd100, 4, 33'h1_0000_0000, 8'd80, 6'd20, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in_mant  = 33'h0_0000_0003;
      in_exp   = 8'd7;
      @(negedge clk);
      chk("bp valid", 64'(out_valid), 64'd1);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp hold", 64'({out_mant, out_exp, out_shift}), 64'({33'h1_0000_0000, 8'd80, 6'd20}));
    end
    in_valid = 1'b0;
    release_out("bp");

    // Reset in the middle of the second pass of the lzc-20 case.
    @(negedge clk);
    in_mant  = 33'h0_0000_1000;
    in_exp   = 8'd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst in_ready",  64'(in_ready), 64'd1);
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst outs", 64'({out_mant, out_exp, out_shift, out_zero, out_underflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post", 33'h1_8000_0000, 8'd3, 2, 33'h1_8000_0000, 8'd3, 6'd0, 1'b0, 1'b0);
    release_out("post");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
